// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: frame-synchronous bouncing motion with pause and speed keys.
// Define SPRITE_MOTION_CTRL_Y_EN to compile in vertical motion; otherwise spr_y is tied to 0.
module sprite_motion_ctrl #(
  parameter int SCREEN_W = 480,
  parameter int SCREEN_H = 272,
  parameter int SPR_W    = 50,
  parameter int SPR_H    = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_pause,
  input  logic       key_faster,
  input  logic       key_slower,
  input  logic [8:0] x,
  input  logic [8:0] y,
  output logic [8:0] spr_x,
  output logic [8:0] spr_y,
  output logic       hit,
  output logic [2:0] speed,
  output logic       paused,
  output logic [7:0] bounce_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic signed [9:0] X_MAX = 10'(SCREEN_W - SPR_W);

  state_t            r_state, w_state_nxt;
  logic              r_pause_d, r_faster_d, r_slower_d;
  logic              r_pending, r_dir_x_neg, r_hit;
  logic [8:0]        r_spr_x;
  logic [2:0]        r_speed;
  logic [7:0]        r_bounce;
  logic              w_frame_start, w_step;
  logic              w_pause_edge, w_fast_edge, w_slow_edge;
  logic signed [9:0] w_spd, w_x_cur, w_x_nxt;
  logic              w_x_hi, w_x_lo, w_y_bounce;
  logic [8:0]        w_spr_y;

  assign w_frame_start = (x == 9'd0) && (y == 9'd0);
  assign w_pause_edge  = key_pause  & ~r_pause_d;
  assign w_fast_edge   = key_faster & ~r_faster_d;
  assign w_slow_edge   = key_slower & ~r_slower_d;

  // A pause edge wins over a coincident frame start: no step is taken that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    case (r_state)
      IDLE:    if (w_frame_start) w_state_nxt = RUN;
      RUN:     if (w_pause_edge) w_state_nxt = PAUSE;
               else if (w_frame_start && (r_pending || tick)) w_step = 1'b1;
      PAUSE:   if (w_pause_edge) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Signed 10-bit arithmetic so an underflow past 0 shows up as negative.
  assign w_spd   = signed'({7'd0, r_speed});
  assign w_x_cur = signed'({1'b0, r_spr_x});
  assign w_x_nxt = r_dir_x_neg ? (w_x_cur - w_spd) : (w_x_cur + w_spd);
  assign w_x_hi  = w_x_nxt > X_MAX;
  assign w_x_lo  = w_x_nxt < 10'sd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pause_d   <= 1'b0;
      r_faster_d  <= 1'b0;
      r_slower_d  <= 1'b0;
      r_pending   <= 1'b0;
      r_dir_x_neg <= 1'b0;
      r_spr_x     <= 9'd0;
      r_speed     <= 3'd1;
      r_bounce    <= 8'd0;
      r_hit       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pause_d  <= key_pause;
      r_faster_d <= key_faster;
      r_slower_d <= key_slower;
      r_pending  <= (r_state == RUN) && !w_pause_edge && !w_step && (r_pending || tick);
      if (w_step) begin
        if (w_x_hi) begin
          r_spr_x     <= X_MAX[8:0];
          r_dir_x_neg <= 1'b1;
        end else if (w_x_lo) begin
          r_spr_x     <= 9'd0;
          r_dir_x_neg <= 1'b0;
        end else begin
          r_spr_x     <= w_x_nxt[8:0];
        end
        r_bounce <= r_bounce + 8'(w_x_hi || w_x_lo) + 8'(w_y_bounce);
      end
      if (w_fast_edge && !w_slow_edge && r_speed != 3'd7)
        r_speed <= r_speed + 3'd1;
      else if (w_slow_edge && !w_fast_edge && r_speed != 3'd1)
        r_speed <= r_speed - 3'd1;
      r_hit <= ({1'b0, x} >= {1'b0, r_spr_x}) && ({1'b0, x} < {1'b0, r_spr_x} + 10'(SPR_W)) &&
               ({1'b0, y} >= {1'b0, w_spr_y}) && ({1'b0, y} < {1'b0, w_spr_y} + 10'(SPR_H));
    end
  end

`ifdef SPRITE_MOTION_CTRL_Y_EN
  localparam logic signed [9:0] Y_MAX = 10'(SCREEN_H - SPR_H);
  logic              r_dir_y_neg;
  logic [8:0]        r_spr_y;
  logic signed [9:0] w_y_nxt;
  logic              w_y_hi, w_y_lo;

  assign w_y_nxt    = r_dir_y_neg ? (signed'({1'b0, r_spr_y}) - w_spd) : (signed'({1'b0, r_spr_y}) + w_spd);
  assign w_y_hi     = w_y_nxt > Y_MAX;
  assign w_y_lo     = w_y_nxt < 10'sd0;
  assign w_y_bounce = w_step && (w_y_hi || w_y_lo);
  assign w_spr_y    = r_spr_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_spr_y     <= 9'd0;
      r_dir_y_neg <= 1'b0;
    end else if (w_step) begin
      if (w_y_hi) begin
        r_spr_y     <= Y_MAX[8:0];
        r_dir_y_neg <= 1'b1;
      end else if (w_y_lo) begin
        r_spr_y     <= 9'd0;
        r_dir_y_neg <= 1'b0;
      end else begin
        r_spr_y     <= w_y_nxt[8:0];
      end
    end
  end
`else
  assign w_y_bounce = 1'b0;
  assign w_spr_y    = 9'd0;
`endif

  assign spr_x      = r_spr_x;
  assign spr_y      = w_spr_y;
  assign hit        = r_hit;
  assign speed      = r_speed;
  assign paused     = (r_state == PAUSE);
  assign bounce_cnt = r_bounce;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl (default build, vertical motion disabled).
module tb_sprite_motion_ctrl;
  logic       clock = 1'b0;
  logic       reset, tick, key_pause, key_faster, key_slower;
  logic [8:0] x, y, spr_x, spr_y;
  logic       hit, paused;
  logic [2:0] speed;
  logic [7:0] bounce_cnt;
  int         n_assert = 0;
  int         n_fail   = 0;

  sprite_motion_ctrl dut (
    .clock(clock), .reset(reset), .tick(tick),
    .key_pause(key_pause), .key_faster(key_faster), .key_slower(key_slower),
    .x(x), .y(y), .spr_x(spr_x), .spr_y(spr_y), .hit(hit),
    .speed(speed), .paused(paused), .bounce_cnt(bounce_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: tick cycles mid-frame, then the frame-start cycle.
  task automatic frame(input int ticks);
    for (int i = 0; i < ticks; i++) begin
      tick = 1'b1; x = 9'd1; y = 9'd1; cyc();
    end
    tick = 1'b0; x = 9'd0; y = 9'd0; cyc();
    x = 9'd1; y = 9'd1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1);
  endtask

  // which: 0 pause, 1 faster, 2 slower, 3 faster+slower together
  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      key_pause  = (which == 0);
      key_faster = (which == 1) || (which == 3);
      key_slower = (which == 2) || (which == 3);
      cyc();
      key_pause = 1'b0; key_faster = 1'b0; key_slower = 1'b0;
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; key_pause = 1'b0; key_faster = 1'b0; key_slower = 1'b0;
    x = 9'd5; y = 9'd5;
    cyc(); cyc();
    chk("rst_spr_x", spr_x, 0);
    chk("rst_spr_y", spr_y, 0);
    chk("rst_speed", speed, 1);
    chk("rst_bounce", bounce_cnt, 0);
    chk("rst_hit", hit, 0);
    chk("rst_paused", paused, 0);

    reset = 1'b0; x = 9'd1; y = 9'd1; tick = 1'b1;
    cyc();
    chk("idle_hit", hit, 1);
    tick = 1'b0;
    frame(0);
    chk("idle_to_run_x0", spr_x, 0);
    frame(1);
    chk("run_x1", spr_x, 1);
    frame(1);
    chk("run_x2", spr_x, 2);
    chk("run_bounce0", bounce_cnt, 0);

    frame(5);
    chk("five_ticks_one_step", spr_x, 3);
    frame(0);
    chk("no_tick_no_step", spr_x, 3);

    key_faster = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    key_faster = 1'b0; cyc();
    chk("held_faster", speed, 2);
    pulse(1, 1);
    chk("faster_pulse", speed, 3);
    pulse(1, 7);
    chk("faster_sat7", speed, 7);
    pulse(3, 1);
    chk("both_keys", speed, 7);
    pulse(2, 1);
    chk("slower_pulse", speed, 6);
    pulse(2, 8);
    chk("slower_sat1", speed, 1);
    chk("keys_no_move", spr_x, 3);

    pulse(1, 6);
    frames(60);
    chk("x_423", spr_x, 423);
    pulse(2, 2);
    frame(1);
    chk("x_428", spr_x, 428);
    pulse(2, 2);
    chk("speed3", speed, 3);
    frame(1);
    chk("clamp_hi_x", spr_x, 430);
    chk("clamp_hi_bounce", bounce_cnt, 1);
    frame(1);
    chk("dir_neg_x", spr_x, 427);
    pulse(1, 4);
    frames(61);
    chk("exact_lo_x", spr_x, 0);
    chk("exact_lo_nobounce", bounce_cnt, 1);
    frame(1);
    chk("clamp_lo_x", spr_x, 0);
    chk("clamp_lo_bounce", bounce_cnt, 2);
    frame(1);
    chk("dir_pos_x", spr_x, 7);
    frames(60);
    pulse(2, 4);
    frame(1);
    chk("exact_hi_x", spr_x, 430);
    chk("exact_hi_nobounce", bounce_cnt, 2);
    frame(1);
    chk("exact_hi_noflip_x", spr_x, 430);
    chk("exact_hi_noflip_bounce", bounce_cnt, 3);
    chk("y_static", spr_y, 0);

    key_pause = 1'b1; cyc();
    chk("pause_on", paused, 1);
    key_pause = 1'b0; cyc();
    frames(3);
    chk("pause_hold_x", spr_x, 430);
    chk("pause_still", paused, 1);
    pulse(0, 1);
    chk("pause_off", paused, 0);
    frame(0);
    chk("pause_ticks_dropped", spr_x, 430);
    frame(1);
    chk("resume_step", spr_x, 427);

    pulse(0, 1);
    chk("pause_again", paused, 1);
    reset = 1'b1; tick = 1'b1; key_pause = 1'b1; cyc();
    reset = 1'b0; tick = 1'b0; key_pause = 1'b0;
    chk("rst_in_pause_paused", paused, 0);
    chk("rst_in_pause_x", spr_x, 0);
    chk("rst_in_pause_bounce", bounce_cnt, 0);
    chk("rst_in_pause_speed", speed, 1);

    x = 9'd1; y = 9'd1; cyc();
    frame(0);
    pulse(1, 4);
    frames(20);
    chk("x_100", spr_x, 100);
    x = 9'd100; y = 9'd0; cyc();
    chk("hit_corner", hit, 1);
    x = 9'd150; cyc();
    chk("hit_x_right_out", hit, 0);
    x = 9'd149; y = 9'd99; cyc();
    chk("hit_far_corner", hit, 1);
    x = 9'd99; y = 9'd50; cyc();
    chk("hit_x_left_out", hit, 0);
    x = 9'd120; y = 9'd100; cyc();
    chk("hit_y_out", hit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 480, visible LCD width in pixels.
REQ-002 Parameter SCREEN_H, default 272, visible LCD height in pixels.
REQ-003 Parameter SPR_W, default 50, sprite width; SPR_H, default 100, sprite height.
REQ-004 Port clock, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port tick, input, 1, one-cycle motion strobe from the strobe generator.
REQ-007 Port key_pause / key_faster / key_slower, input, 1 each, raw level-sensitive keys.
REQ-008 Port x / y, input, 9 each, current LCD pixel coordinate.
REQ-009 Port spr_x / spr_y, output, 9 each, sprite top-left corner in pixels.
REQ-010 Port hit, output, 1, registered flag: the previous cycle's (x,y) lies inside the sprite.
REQ-011 Port speed, output, 3, pixels moved per applied step, range 1..7.
REQ-012 Port paused, output, 1, high in state PAUSE.
REQ-013 Port bounce_cnt, output, 8, number of wall bounces, wrapping mod 256.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 IDLE -> RUN on the first cycle with x==0 and y==0 (frame_start); no motion occurs in IDLE.
REQ-016 RUN <-> PAUSE on each rising edge of key_pause, detected against a 1-cycle delayed copy of the key.
REQ-017 In RUN, tick SHALL set a single-bit pending flag; several ticks within one frame yield only one step.
REQ-018 On frame_start in RUN with pending set, or with tick asserted in that same cycle, the block SHALL apply one step and clear pending.
REQ-019 Step in x: next = spr_x +/- speed according to dir_x; positions SHALL be computed 10 bits wide to avoid wrap.
REQ-020 If next x > SCREEN_W-SPR_W, spr_x SHALL clamp to SCREEN_W-SPR_W, dir_x SHALL become negative, and bounce_cnt SHALL increment.
REQ-021 If next x < 0, spr_x SHALL clamp to 0, dir_x SHALL become positive, and bounce_cnt SHALL increment.
REQ-022 A step that lands exactly on a limit SHALL NOT count as a bounce and SHALL NOT flip direction.
REQ-023 Y motion, when enabled (REQ-034), SHALL use the same rules with SCREEN_H-SPR_H; a simultaneous x and y bounce SHALL add 2 to bounce_cnt.
REQ-024 Entering PAUSE SHALL clear pending; in PAUSE, ticks SHALL be ignored and positions held.
REQ-025 A key_faster rising edge SHALL increment speed, saturating at 7; a key_slower rising edge SHALL decrement it, saturating at 1.
REQ-026 Speed changes SHALL be accepted in every state; rising edges of both keys in the same cycle SHALL leave speed unchanged.
REQ-027 hit SHALL be registered as spr_x <= x < spr_x+SPR_W and spr_y <= y < spr_y+SPR_H, giving 1-cycle latency.
REQ-028 Position outputs SHALL change only on the frame_start cycle (tear-free update).

Reset
REQ-029 Reset SHALL force state IDLE, spr_x=0, spr_y=0, dir_x and dir_y positive, speed=1, pending=0, bounce_cnt=0, hit=0, paused=0.
REQ-030 Reset SHALL clear the key edge-detect registers to 0, so a key held through reset produces no edge.
REQ-031 Reset asserted mid-frame or while PAUSE SHALL take priority over all other events in that cycle.

Configuration
REQ-032 The macro SPRITE_MOTION_CTRL_Y_EN SHALL select whether vertical motion is compiled in.
REQ-033 Without the macro, spr_y SHALL stay constant at 0, and dir_y and its logic SHALL be absent.
REQ-034 With the macro, spr_y SHALL move per REQ-023 using the same speed value as x.

Verification
REQ-035 Reset, tick each frame, speed=1, frame_start x3 -> spr_x = 0,1,2 after successive frame starts; bounce_cnt=0.
REQ-036 Five ticks within one frame, then frame_start -> spr_x advances by exactly speed (one step).
REQ-037 spr_x=428, speed=3, dir +, step -> spr_x=430, dir_x negative, bounce_cnt=1; spr_x=430 reached by exact landing -> no bounce.
REQ-038 key_pause pulse, then ticks over 3 frames -> paused=1 and spr_x unchanged; second pulse -> RUN, next frame steps.
REQ-039 key_faster held 10 cycles, then 8 separate pulses -> speed=2 after the held key, saturating at 7; both keys pulsed together -> unchanged.
REQ-040 spr_x=100, spr_y=0: x=100,y=0 -> hit=1 one cycle later; x=150 -> hit=0.
